// File: rtl/pla_in5_resp_buffer.sv
// Response buffer behind the in5 PLA decoder: FWFT FIFO, sample counter, drop flag.
// Latency: one cycle from push to out_valid/out_data when the FIFO is empty.
// Backpressure: in_ready = not full (state only); samples offered while full are dropped and set ovf.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   decoder sample handshake, in_data[WIDTH-1:0] = z(i)
//   out_valid/out_ready head-of-FIFO handshake, out_data = oldest sample
//   level               occupancy 0..DEPTH
//   ovf, ovf_clr        sticky drop flag and its synchronous clear
//   sample_cnt          saturating count of accepted samples
//   misr_sig, misr_clr  signature of accepted samples (only with PLA_IN5_MISR_EN defined)
module pla_in5_resp_buffer #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
`ifdef PLA_IN5_MISR_EN
    parameter int CNT_W = 16,
    parameter logic [WIDTH-1:0] MISR_POLY = 14'h1053
`else
    parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         sample_cnt
`ifdef PLA_IN5_MISR_EN
    ,
    output logic [WIDTH-1:0]         misr_sig,
    input  logic                     misr_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Full/empty decoded from level only, so out_ready never reaches in_ready.
    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage carries no reset; contents are ignored while level is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Push+pop together leaves level alone; at level 1 the new sample
            // lands at wr_ptr == rd_ptr+1, which becomes the head next cycle.
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop while full sets ovf; set wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (push && (sample_cnt != '1)) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

`ifdef PLA_IN5_MISR_EN
    // Shift left, fold the outgoing MSB back through the taps, then mix in the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr_sig <= '0;
        end else if (misr_clr) begin
            misr_sig <= '0;
        end else if (push) begin
            misr_sig <= ({misr_sig[WIDTH-2:0], 1'b0}
                         ^ (misr_sig[WIDTH-1] ? MISR_POLY : '0))
                        ^ in_data;
        end
    end
`endif

endmodule
